vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
- Multi-product vending controller built on the nickel/dime/quarter coin-pulse interface.
- Accumulates credit and arbitrates between coin entry, purchase, and refund.
- Sequences a dispense handshake with the product mechanism, then pays out change through a coin-return handshake.
- Sits between the coin acceptor and the dispenser and change-hopper actuators.

Parameters:
- CREDIT_W, 5, credit width in nickel units (5¢ per LSB).
- MAX_CREDIT, 20, credit ceiling in nickels (100¢); must be < 2**CREDIT_W.
- PRICE0, 3, product 0 price in nickels (15¢).
- PRICE1, 5, product 1 price (25¢).
- PRICE2, 7, product 2 price (35¢).
- PRICE3, 10, product 3 price (50¢).
- Each PRICEn must satisfy 1 ≤ PRICEn ≤ MAX_CREDIT; an elaboration-time assertion enforces this.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- N  in  1  nickel pulse, one cycle
- D  in  1  dime pulse, one cycle
- Q  in  1  quarter pulse, one cycle
- sel  in  2  product select, sampled with buy
- buy  in  1  purchase request pulse
- refund  in  1  refund request pulse
- dispense_req  out  1  dispense request, level
- dispense_sel  out  2  latched product index, valid while dispense_req
- dispense_ack  in  1  dispenser done, one cycle
- chg_nickel  out  1  eject-one-nickel request, level
- chg_dime  out  1  eject-one-dime request (CHANGE_DIME_EN only; tied 0 otherwise)
- chg_ack  in  1  coin ejected, one cycle
- credit  out  CREDIT_W  current credit in nickels
- reject  out  1  coin returned by the chute, one-cycle pulse
- deny  out  1  buy refused, one-cycle pulse
- busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, credit 0.
  - All outputs 0; dispense_sel 0.
  - A reset in VEND or CHANGE drops requests immediately; remaining credit is forfeited.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE. All outputs are registered.
- Coin valuation: N=1, D=2, Q=5.
  - Zero-hot coin input: no action.
  - Multi-hot coin input: reject pulse next cycle, credit unchanged.
- IDLE/CREDIT coin handling:
  - If credit+value ≤ MAX_CREDIT: add value next cycle and go to CREDIT.
  - Otherwise: reject pulse, credit unchanged. Exactly reaching MAX_CREDIT is accepted.
- Priority in IDLE/CREDIT: buy > refund > coin.
  - Any coin arriving in the same cycle as a serviced buy or refund is rejected.
- buy in CREDIT with credit ≥ PRICE[sel]:
  - Next cycle: credit -= PRICE[sel], dispense_sel <= sel, dispense_req=1, state VEND.
- buy with insufficient credit, or buy in IDLE: deny pulse next cycle, no state change.
- refund:
  - In CREDIT: go to CHANGE.
  - In IDLE: ignored.
- VEND:
  - dispense_req held until dispense_ack; it deasserts the cycle after the ack.
  - After the ack: go to CHANGE if credit>0, else IDLE.
  - buy and refund are ignored; all coins are rejected.
- CHANGE:
  - Exactly one chg_* request asserted at a time, held until chg_ack.
  - On ack: credit decrements by the coin value. The next request appears one cycle later, or the state returns to IDLE when credit==0.
  - Coins rejected; buy and refund ignored.
- Latency:
  - Coin to credit update: 1 cycle.
  - buy to dispense_req: 1 cycle.
  - dispense_ack to first chg request: 1 cycle.
- Acks arriving outside their handshake window are ignored.
- Credit never underflows and never exceeds MAX_CREDIT; covered by assertions.

Optional Feature:
- Macro: VEND_CTRL_CHANGE_DIME_EN.
- Defined: CHANGE pays a dime (chg_dime) while credit ≥ 2 and a nickel for a final odd unit. For example, 7 → dime, dime, dime, nickel.
- Undefined: change is paid in nickels only; chg_dime is constant 0.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_t {IDLE, VEND_CREDIT, VEND, CHANGE}
  - localparams NICKEL_VAL=1, DIME_VAL=2, QUARTER_VAL=5
  - function coin_value({N,D,Q}), returning value or 0 for invalid input
- Sub-module vend_change_seq owns the CHANGE handshake.
  - Inputs: start, amount, chg_ack.
  - Outputs: chg_nickel, chg_dime, remaining, done.
  - The dime/nickel policy is contained here.

Test Plan:
- Reset mid-CHANGE: drive reset low while chg_nickel=1 → all outputs 0 asynchronously, credit 0; after release, the next N gives credit=1.
- Coin sequence Q, D (credit 7), buy sel=0 → dispense_req=1 and dispense_sel=0 one cycle later, credit=4. After dispense_ack, four nickel handshakes (dimes build: D,D) → credit 0, IDLE.
- Credit 18, insert Q → reject pulse, credit stays 18. Insert D → credit 20. Insert N → reject.
- Credit 4, buy sel=1 → deny pulse, credit 4, no dispense_req. Refund → four nickels, then IDLE.
- N and D asserted together → reject pulse, credit unchanged. Q in the same cycle as a valid buy → buy serviced, Q rejected.
- Exact payment: credit 10, buy sel=3 → VEND; after dispense_ack, direct to IDLE with no chg_* asserted; busy high exactly during VEND.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, coin values and coin decoding for the vending controller.
// Imported by vend_ctrl and vend_change_seq.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VEND_CREDIT,
    VEND,
    CHANGE
  } vend_state_t;

  localparam int NICKEL_VAL  = 1;
  localparam int DIME_VAL    = 2;
  localparam int QUARTER_VAL = 5;

  // {N,D,Q} -> value in nickels; zero-hot and multi-hot both give 0
  function automatic logic [2:0] coin_value(input logic [2:0] ndq);
    logic [2:0] v;
    case (ndq)
      3'b100:  v = 3'(NICKEL_VAL);
      3'b010:  v = 3'(DIME_VAL);
      3'b001:  v = 3'(QUARTER_VAL);
      default: v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_seq.sv
// Change payout sequencer: one coin request at a time, held until ack.
// Ports: clk, rst_n, start_i, amount_i, chg_ack_i -> chg_nickel_o,
//   chg_dime_o, remaining_o, done_o.
// VEND_CTRL_CHANGE_DIME_EN: pay dimes while 2+ units remain,
//   otherwise nickels only (chg_dime_o stays 0).
module vend_change_seq
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [CREDIT_W-1:0] amount_i,
  input  logic                chg_ack_i,
  output logic                chg_nickel_o,
  output logic                chg_dime_o,
  output logic [CREDIT_W-1:0] remaining_o,
  output logic                done_o
);

`ifdef VEND_CTRL_CHANGE_DIME_EN
  localparam bit DimeEn = 1'b1;
`else
  localparam bit DimeEn = 1'b0;
`endif

  function automatic logic use_dime(
    input logic [CREDIT_W-1:0] r
  );
    return DimeEn && (r >= CREDIT_W'(DIME_VAL));
  endfunction

  logic [CREDIT_W-1:0] rem_q;
  logic [CREDIT_W-1:0] rem_d;
  logic [CREDIT_W-1:0] ack_val;
  logic                nick_q;
  logic                dime_q;
  logic                pend_q;
  logic                req;
  logic                ack;

  assign req     = nick_q | dime_q;
  assign ack     = req & chg_ack_i;
  assign ack_val = dime_q ? CREDIT_W'(DIME_VAL)
                          : CREDIT_W'(NICKEL_VAL);
  assign rem_d   = rem_q - ack_val;

  // pend_q inserts one idle cycle between handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      nick_q <= 1'b0;
      dime_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= amount_i;
      dime_q <= use_dime(amount_i);
      nick_q <= !use_dime(amount_i) &&
                (amount_i != '0);
      pend_q <= 1'b0;
    end else if (ack) begin
      rem_q  <= rem_d;
      nick_q <= 1'b0;
      dime_q <= 1'b0;
      pend_q <= (rem_d != '0);
    end else if (pend_q) begin
      dime_q <= use_dime(rem_q);
      nick_q <= !use_dime(rem_q);
      pend_q <= 1'b0;
    end
  end

  assign chg_nickel_o = nick_q;
  assign chg_dime_o   = dime_q;
  assign remaining_o  = rem_q;
  assign done_o       = ack && (rem_d == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, purchase, dispense and change handshakes.
// Ports: clk, reset (async, low), N/D/Q coin pulses, sel, buy, refund,
//   dispense_req/sel/ack, chg_nickel/dime/ack, credit, reject, deny, busy.
// VEND_CTRL_CHANGE_DIME_EN (in vend_change_seq) enables dime change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 5,
  parameter int PRICE2     = 7,
  parameter int PRICE3     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic [1:0]          sel,
  input  logic                buy,
  input  logic                refund,
  output logic                dispense_req,
  output logic [1:0]          dispense_sel,
  input  logic                dispense_ack,
  output logic                chg_nickel,
  output logic                chg_dime,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic                deny,
  output logic                busy
);

  if (PRICE0 < 1 || PRICE0 > MAX_CREDIT ||
      PRICE1 < 1 || PRICE1 > MAX_CREDIT ||
      PRICE2 < 1 || PRICE2 > MAX_CREDIT ||
      PRICE3 < 1 || PRICE3 > MAX_CREDIT ||
      MAX_CREDIT >= 2**CREDIT_W) begin : g_bad_cfg
    $error("vend_ctrl: price or credit range invalid");
  end

  vend_state_t         state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                disp_req_q;
  logic [1:0]          disp_sel_q;
  logic                reject_q;
  logic                deny_q;
  logic                busy_q;

  logic [2:0]          cval;
  logic                coin_any;
  logic                coin_bad;
  logic [CREDIT_W:0]   sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] price;
  logic                can_buy;
  logic                in_shop;
  logic                do_refund;
  logic                seq_start;
  logic                chg_req;
  logic                chg_ackd;
  logic [CREDIT_W-1:0] ack_val;
  logic [CREDIT_W-1:0] seq_rem;
  logic                seq_done;

  assign cval      = coin_value({N, D, Q});
  assign coin_any  = N | D | Q;
  assign coin_bad  = coin_any && (cval == 3'd0);
  assign sum       = {1'b0, credit_q} +
                     (CREDIT_W+1)'(cval);
  assign coin_fits = sum <= (CREDIT_W+1)'(MAX_CREDIT);

  always_comb begin
    price = CREDIT_W'(PRICE0);
    unique case (sel)
      2'd0: price = CREDIT_W'(PRICE0);
      2'd1: price = CREDIT_W'(PRICE1);
      2'd2: price = CREDIT_W'(PRICE2);
      2'd3: price = CREDIT_W'(PRICE3);
    endcase
  end

  assign in_shop   = (state_q == IDLE) ||
                     (state_q == VEND_CREDIT);
  assign can_buy   = (state_q == VEND_CREDIT) &&
                     (credit_q >= price);
  assign do_refund = (state_q == VEND_CREDIT) &&
                     !buy && refund;
  // payout starts on the same edge the FSM enters CHANGE
  assign seq_start = do_refund ||
                     ((state_q == VEND) && dispense_ack &&
                      (credit_q != '0));
  assign chg_req   = chg_nickel | chg_dime;
  assign chg_ackd  = (state_q == CHANGE) && chg_req &&
                     chg_ack;
  assign ack_val   = chg_dime ? CREDIT_W'(DIME_VAL)
                              : CREDIT_W'(NICKEL_VAL);

  vend_change_seq #(
    .CREDIT_W (CREDIT_W)
  ) u_chg (
    .clk          (clk),
    .rst_n        (reset),
    .start_i      (seq_start),
    .amount_i     (credit_q),
    .chg_ack_i    (chg_ack),
    .chg_nickel_o (chg_nickel),
    .chg_dime_o   (chg_dime),
    .remaining_o  (seq_rem),
    .done_o       (seq_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      disp_req_q <= 1'b0;
      disp_sel_q <= 2'd0;
      reject_q   <= 1'b0;
      deny_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      deny_q   <= 1'b0;
      case (state_q)
        IDLE, VEND_CREDIT: begin
          if (buy) begin
            // a buy, served or denied, owns the cycle
            reject_q <= coin_any;
            if (can_buy) begin
              credit_q   <= credit_q - price;
              disp_sel_q <= sel;
              disp_req_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= VEND;
            end else begin
              deny_q <= 1'b1;
            end
          end else if (do_refund) begin
            reject_q <= coin_any;
            busy_q   <= 1'b1;
            state_q  <= CHANGE;
          end else if (coin_any) begin
            if (!coin_bad && coin_fits) begin
              credit_q <= sum[CREDIT_W-1:0];
              state_q  <= VEND_CREDIT;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        VEND: begin
          reject_q <= coin_any;
          if (dispense_ack) begin
            disp_req_q <= 1'b0;
            if (credit_q != '0) begin
              state_q <= CHANGE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          reject_q <= coin_any;
          if (chg_ackd) begin
            credit_q <= credit_q - ack_val;
            if (seq_done) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dispense_req = disp_req_q;
  assign dispense_sel = disp_sel_q;
  assign credit       = credit_q;
  assign reject       = reject_q;
  assign deny         = deny_q;
  assign busy         = busy_q;

  a_credit_max: assert property (
    @(posedge clk) disable iff (!reset)
    credit_q <= CREDIT_W'(MAX_CREDIT));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!reset)
    chg_ackd |-> credit_q >= ack_val);

  a_seq_tracks: assert property (
    @(posedge clk) disable iff (!reset)
    chg_req |-> seq_rem == credit_q);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (default build, nickel change).
// Tasks per scenario, each with inline comparisons.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       N = 1'b0;
  logic       D = 1'b0;
  logic       Q = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       buy = 1'b0;
  logic       refund = 1'b0;
  logic       dispense_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       dispense_req;
  logic [1:0] dispense_sel;
  logic       chg_nickel;
  logic       chg_dime;
  logic [4:0] credit;
  logic       reject;
  logic       deny;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .N            (N),
    .D            (D),
    .Q            (Q),
    .sel          (sel),
    .buy          (buy),
    .refund       (refund),
    .dispense_req (dispense_req),
    .dispense_sel (dispense_sel),
    .dispense_ack (dispense_ack),
    .chg_nickel   (chg_nickel),
    .chg_dime     (chg_dime),
    .chg_ack      (chg_ack),
    .credit       (credit),
    .reject       (reject),
    .deny         (deny),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic n, input logic d,
                      input logic q);
    N = n; D = d; Q = q;
    tick();
    N = 0; D = 0; Q = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    N = 0; D = 0; Q = 0; buy = 0; refund = 0;
    dispense_ack = 0; chg_ack = 0; sel = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  task automatic press_buy(input logic [1:0] s);
    sel = s; buy = 1;
    tick();
    buy = 0;
  endtask

  task automatic pulse_dack();
    dispense_ack = 1;
    tick();
    dispense_ack = 0;
  endtask

  // n nickel handshakes from credit n down to 0
  task automatic drain(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!chg_nickel && w < 8) begin
        tick();
        w++;
      end
      n_chk++;
      if (chg_nickel !== 1'b1 || chg_dime !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_req%0d: nickel=%b dime=%b want 1/0",
                 tag, k, chg_nickel, chg_dime);
      end
      chg_ack = 1;
      tick();
      chg_ack = 0;
      n_chk++;
      if (credit !== 5'(n - 1 - k)) begin
        n_fail++;
        $display("FAIL %s_credit%0d: got %0d want %0d",
                 tag, k, credit, n - 1 - k);
      end
      n_chk++;
      if (busy !== (k < n - 1) || chg_nickel !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_post%0d: busy=%b nickel=%b",
                 tag, k, busy, chg_nickel);
      end
    end
    tick();
    n_chk++;
    if ({chg_nickel, chg_dime, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_idle: nickel=%b dime=%b busy=%b want 0",
               tag, chg_nickel, chg_dime, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({dispense_req, dispense_sel, chg_nickel, chg_dime,
         credit, reject, deny, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0",
               {dispense_req, dispense_sel, chg_nickel,
                chg_dime, credit, reject, deny, busy});
    end
  endtask

  task automatic test_vend_change();
    do_reset();
    coin(0, 0, 1);
    coin(0, 1, 0);
    n_chk++;
    if (credit !== 5'd7) begin
      n_fail++;
      $display("FAIL vc_credit7: got %0d want 7", credit);
    end
    press_buy(2'd0);
    n_chk++;
    if (dispense_req !== 1'b1 || dispense_sel !== 2'd0 ||
        credit !== 5'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL vc_buy: req=%b sel=%0d cr=%0d busy=%b want 1/0/4/1",
               dispense_req, dispense_sel, credit, busy);
    end
    tick();
    n_chk++;
    if (dispense_req !== 1'b1) begin
      n_fail++;
      $display("FAIL vc_hold: req=%b want 1", dispense_req);
    end
    pulse_dack();
    n_chk++;
    if (dispense_req !== 1'b0 || chg_nickel !== 1'b1 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL vc_ack: req=%b nickel=%b busy=%b want 0/1/1",
               dispense_req, chg_nickel, busy);
    end
    drain(4, "vc");
  endtask

  task automatic test_ceiling();
    do_reset();
    coin(0, 0, 1);
    coin(0, 0, 1);
    coin(0, 0, 1);
    coin(0, 1, 0);
    coin(1, 0, 0);
    n_chk++;
    if (credit !== 5'd18) begin
      n_fail++;
      $display("FAIL ceil_18: got %0d want 18", credit);
    end
    coin(0, 0, 1);
    n_chk++;
    if (reject !== 1'b1 || credit !== 5'd18) begin
      n_fail++;
      $display("FAIL ceil_q: rej=%b cr=%0d want 1/18",
               reject, credit);
    end
    coin(0, 1, 0);
    n_chk++;
    if (reject !== 1'b0 || credit !== 5'd20) begin
      n_fail++;
      $display("FAIL ceil_d: rej=%b cr=%0d want 0/20",
               reject, credit);
    end
    coin(1, 0, 0);
    n_chk++;
    if (reject !== 1'b1 || credit !== 5'd20) begin
      n_fail++;
      $display("FAIL ceil_n: rej=%b cr=%0d want 1/20",
               reject, credit);
    end
    tick();
    n_chk++;
    if (reject !== 1'b0) begin
      n_fail++;
      $display("FAIL ceil_pulse: rej=%b want 0", reject);
    end
  endtask

  task automatic test_deny_refund();
    do_reset();
    press_buy(2'd2);
    n_chk++;
    if (deny !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_idle_buy: deny=%b busy=%b want 1/0",
               deny, busy);
    end
    coin(0, 1, 0);
    coin(0, 1, 0);
    press_buy(2'd1);
    n_chk++;
    if (deny !== 1'b1 || credit !== 5'd4 ||
        dispense_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_deny: deny=%b cr=%0d req=%b busy=%b want 1/4/0/0",
               deny, credit, dispense_req, busy);
    end
    tick();
    n_chk++;
    if (deny !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_pulse: deny=%b want 0", deny);
    end
    refund = 1;
    tick();
    refund = 0;
    n_chk++;
    if (busy !== 1'b1 || chg_nickel !== 1'b1) begin
      n_fail++;
      $display("FAIL dr_refund: busy=%b nickel=%b want 1/1",
               busy, chg_nickel);
    end
    drain(4, "dr");
    refund = 1;
    tick();
    refund = 0;
    n_chk++;
    if (busy !== 1'b0 || credit !== 5'd0) begin
      n_fail++;
      $display("FAIL dr_idle_refund: busy=%b cr=%0d want 0/0",
               busy, credit);
    end
  endtask

  task automatic test_multi_hot();
    do_reset();
    coin(1, 0, 0);
    coin(1, 1, 0);
    n_chk++;
    if (reject !== 1'b1 || credit !== 5'd1) begin
      n_fail++;
      $display("FAIL mh_nd: rej=%b cr=%0d want 1/1",
               reject, credit);
    end
    coin(0, 1, 0);
    n_chk++;
    if (reject !== 1'b0 || credit !== 5'd3) begin
      n_fail++;
      $display("FAIL mh_d: rej=%b cr=%0d want 0/3",
               reject, credit);
    end
    sel = 2'd0; buy = 1; Q = 1;
    tick();
    buy = 0; Q = 0;
    n_chk++;
    if (dispense_req !== 1'b1 || reject !== 1'b1 ||
        credit !== 5'd0) begin
      n_fail++;
      $display("FAIL mh_buyq: req=%b rej=%b cr=%0d want 1/1/0",
               dispense_req, reject, credit);
    end
    coin(1, 0, 0);
    n_chk++;
    if (reject !== 1'b1 || credit !== 5'd0 ||
        dispense_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mh_vend_coin: rej=%b cr=%0d req=%b want 1/0/1",
               reject, credit, dispense_req);
    end
    pulse_dack();
    n_chk++;
    if (dispense_req !== 1'b0 || busy !== 1'b0 ||
        chg_nickel !== 1'b0) begin
      n_fail++;
      $display("FAIL mh_done: req=%b busy=%b nickel=%b want 0",
               dispense_req, busy, chg_nickel);
    end
  endtask

  task automatic test_exact();
    do_reset();
    coin(0, 0, 1);
    coin(0, 0, 1);
    press_buy(2'd3);
    n_chk++;
    if (dispense_req !== 1'b1 || dispense_sel !== 2'd3 ||
        credit !== 5'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_buy: req=%b sel=%0d cr=%0d busy=%b want 1/3/0/1",
               dispense_req, dispense_sel, credit, busy);
    end
    tick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_busy: busy=%b want 1", busy);
    end
    pulse_dack();
    n_chk++;
    if (dispense_req !== 1'b0 || busy !== 1'b0 ||
        {chg_nickel, chg_dime} !== 2'b00) begin
      n_fail++;
      $display("FAIL ex_ack: req=%b busy=%b chg=%b want 0/0/00",
               dispense_req, busy, {chg_nickel, chg_dime});
    end
    tick();
    n_chk++;
    if ({chg_nickel, chg_dime, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL ex_idle: chg/busy=%b want 000",
               {chg_nickel, chg_dime, busy});
    end
    chg_ack = 1;
    tick();
    chg_ack = 0;
    coin(1, 0, 0);
    pulse_dack();
    n_chk++;
    if (credit !== 5'd1 || dispense_req !== 1'b0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_stray: cr=%0d req=%b busy=%b want 1/0/0",
               credit, dispense_req, busy);
    end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    coin(0, 1, 0);
    coin(0, 1, 0);
    coin(1, 0, 0);
    refund = 1;
    tick();
    refund = 0;
    n_chk++;
    if (chg_nickel !== 1'b1 || credit !== 5'd5) begin
      n_fail++;
      $display("FAIL rm_pre: nickel=%b cr=%0d want 1/5",
               chg_nickel, credit);
    end
    #2 reset = 0;
    #1;
    n_chk++;
    if ({dispense_req, dispense_sel, chg_nickel, chg_dime,
         credit, reject, deny, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL rm_async: got %b want 0",
               {dispense_req, dispense_sel, chg_nickel,
                chg_dime, credit, reject, deny, busy});
    end
    tick();
    reset = 1;
    tick();
    coin(1, 0, 0);
    n_chk++;
    if (credit !== 5'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_after: cr=%0d busy=%b want 1/0",
               credit, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vend_change();
    test_ceiling();
    test_deny_refund();
    test_multi_hot();
    test_exact();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
